// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared types and sizing for the frame send scheduler
// Purpose: scheduler state encoding and byte FIFO sizing.
// Ports: none (package).
package jpeg_pkg;

  localparam int SCHED_FIFO_DEPTH = 2;
  localparam int SCHED_FIFO_CW    = $clog2(SCHED_FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_HEADER,
    S_DATA,
    S_FLUSH,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/send_sched_if.sv
// rtl/send_sched_if.sv - send controller, encoder and downstream byte channel bundle
// Purpose: groups the send-controller handshake, encoder control and the
//          downstream valid/ready byte port.
// Modports: master = scheduler side (drives o_*), slave = environment side (drives i_*).
interface send_sched_if;

  logic       o_send_start;
  logic       o_send_wait;
  logic       i_send_ready;
  logic [7:0] i_send_data;
  logic       i_send_valid;
  logic       i_send_end;
  logic       o_send_data_end;
  logic       o_enc_enable;
  logic       i_enc_done;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (
    output o_send_start, o_send_wait, o_send_data_end, o_enc_enable,
    output o_tx_data, o_tx_valid,
    input  i_send_ready, i_send_data, i_send_valid, i_send_end,
    input  i_enc_done, i_tx_ready
  );

  modport slave (
    input  o_send_start, o_send_wait, o_send_data_end, o_enc_enable,
    input  o_tx_data, o_tx_valid,
    output i_send_ready, i_send_data, i_send_valid, i_send_end,
    output i_enc_done, i_tx_ready
  );

endinterface

// File: rtl/byte_fifo2.sv
// rtl/byte_fifo2.sv - two-entry byte FIFO between send controller and downstream port
// Purpose: buffers captured bytes; no bypass, so a push into an empty FIFO
//          is only visible on the following cycle.
// Ports: clk, rst (async, active-high), push/pop/flush controls, din in,
//        dout (head, 0 when empty), count (occupancy).
module byte_fifo2
  import jpeg_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [SCHED_FIFO_CW-1:0] count
);

  localparam int AW = $clog2(SCHED_FIFO_DEPTH);

  logic [7:0]    mem [SCHED_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != SCHED_FIFO_CW'(SCHED_FIFO_DEPTH));
  assign do_pop  = pop && (count != '0);
  // Head reads as zero when empty so the output never shows stale storage.
  assign dout    = (count != '0) ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + SCHED_FIFO_CW'(do_push) - SCHED_FIFO_CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/send_sched.sv
// rtl/send_sched.sv - frame send scheduler: sequences header, entropy data and flush
// Purpose: accepts a host frame request, starts the send controller, enables
//          the encoder, buffers the send controller byte stream into a
//          2-entry FIFO feeding a valid/ready port, and aborts on idle timeout.
// Ports: clk, rst (async, active-high); bus (send controller, encoder and
//        downstream channel); i_frame_req/o_frame_ack host handshake; o_busy;
//        o_byte_count, o_frame_count, o_err_timeout status.
module send_sched
  import jpeg_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4095,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  send_sched_if.master     bus,
  input  logic             i_frame_req,
  output logic             o_frame_ack,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_byte_count,
  output logic [15:0]      o_frame_count,
  output logic             o_err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  sched_state_t             state;
  logic [TW-1:0]            idle_cyc;
  logic [SCHED_FIFO_CW-1:0] fifo_cnt;
  logic                     end_seen;
  logic                     data_end_q;
  logic                     push;
  logic                     pop;
  logic                     capture_st;
  logic                     timed_st;
  logic                     leave_st;
  logic                     timeout_hit;

  assign capture_st = (state == S_HEADER) || (state == S_DATA) || (state == S_FLUSH);
  assign timed_st   = (state == S_HEADER) || (state == S_FLUSH);

  // Stall is a pure occupancy decode, so a pop in the same cycle cannot release it.
  assign bus.o_send_wait = (fifo_cnt == SCHED_FIFO_CW'(SCHED_FIFO_DEPTH));
  assign push            = capture_st && bus.i_send_valid && !bus.o_send_wait;
  assign bus.o_tx_valid  = (fifo_cnt != '0);
  assign pop             = bus.o_tx_valid && bus.i_tx_ready;

  // A legitimate state exit takes priority over an abort in the same cycle.
  assign leave_st    = ((state == S_HEADER) && bus.i_send_ready) ||
                       ((state == S_FLUSH) && end_seen && (fifo_cnt == '0));
  assign timeout_hit = timed_st && !push && !leave_st &&
                       (idle_cyc == TW'(TIMEOUT_CYC - 1));

  assign o_busy              = (state != S_IDLE);
  assign o_frame_ack         = (state == S_START);
  assign bus.o_send_start    = (state == S_START);
  assign bus.o_enc_enable    = (state == S_DATA) || (state == S_FLUSH);
  assign bus.o_send_data_end = data_end_q;

  byte_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (timeout_hit),
    .din   (bus.i_send_data),
    .dout  (bus.o_tx_data),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idle_cyc      <= '0;
      end_seen      <= 1'b0;
      data_end_q    <= 1'b0;
      o_byte_count  <= '0;
      o_frame_count <= '0;
      o_err_timeout <= 1'b0;
    end else begin
      idle_cyc <= (timed_st && !push) ? idle_cyc + TW'(1) : '0;
      if (pop) o_byte_count <= o_byte_count + CNT_W'(1);
      // Data-end stays up until the send controller has seen it unstalled once.
      if (data_end_q && !bus.o_send_wait) data_end_q <= 1'b0;
      if (push && bus.i_send_end && ((state == S_DATA) || (state == S_FLUSH)))
        end_seen <= 1'b1;

      case (state)
        S_IDLE: begin
          if (i_frame_req) begin
            state         <= S_START;
            o_byte_count  <= '0;
            o_err_timeout <= 1'b0;
            end_seen      <= 1'b0;
          end
        end
        S_START: state <= S_HEADER;
        S_HEADER: begin
          if (bus.i_send_ready) begin
            state    <= S_DATA;
            idle_cyc <= '0;
          end else if (timeout_hit) begin
            state         <= S_IDLE;
            o_err_timeout <= 1'b1;
            idle_cyc      <= '0;
          end
        end
        S_DATA: begin
          if (bus.i_enc_done) begin
            state      <= S_FLUSH;
            data_end_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (leave_st) begin
            state    <= S_DONE;
            idle_cyc <= '0;
          end else if (timeout_hit) begin
            state         <= S_IDLE;
            o_err_timeout <= 1'b1;
            idle_cyc      <= '0;
            data_end_q    <= 1'b0;
            end_seen      <= 1'b0;
          end
        end
        S_DONE: begin
          o_frame_count <= o_frame_count + 16'd1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_send_sched.sv
// tb/tb_send_sched.sv - self-checking bench for send_sched
module tb_send_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ack;
  logic        busy;
  logic [31:0] byte_cnt;
  logic [15:0] frame_cnt;
  logic        err;
  logic        req2 = 1'b0;
  logic        ack2;
  logic        busy2;
  logic [31:0] byte_cnt2;
  logic [15:0] frame_cnt2;
  logic        err2;

  send_sched_if b1 ();
  send_sched_if b2 ();

  send_sched dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (b1),
    .i_frame_req   (req),
    .o_frame_ack   (ack),
    .o_busy        (busy),
    .o_byte_count  (byte_cnt),
    .o_frame_count (frame_cnt),
    .o_err_timeout (err)
  );

  send_sched #(.TIMEOUT_CYC(16)) dut2 (
    .clk           (clk),
    .rst           (rst),
    .bus           (b2),
    .i_frame_req   (req2),
    .o_frame_ack   (ack2),
    .o_busy        (busy2),
    .o_byte_count  (byte_cnt2),
    .o_frame_count (frame_cnt2),
    .o_err_timeout (err2)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mq[$];
  logic [31:0] bc_m = '0;
  logic [15:0] fc_m = '0;
  bit          de_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: a queue of captured-but-not-delivered bytes.
  task automatic tick(output bit cap);
    bit we;
    we = (mq.size() == 2);
    chk("send_wait", b1.o_send_wait, we);
    chk("tx_valid", b1.o_tx_valid, mq.size() != 0);
    if (mq.size() != 0) chk("tx_data", b1.o_tx_data, mq[0]);
    chk("data_end", b1.o_send_data_end, de_exp);
    chk("byte_count", byte_cnt, bc_m);
    if (de_exp && !we) de_exp = 1'b0;
    if (mq.size() != 0 && b1.i_tx_ready) begin
      void'(mq.pop_front());
      bc_m++;
    end
    cap = b1.i_send_valid && !we;
    if (cap) mq.push_back(b1.i_send_data);
  endtask

  task automatic idle_inputs();
    b1.i_send_valid = 1'b0;
    b1.i_send_data  = 8'h00;
    b1.i_send_end   = 1'b0;
    b1.i_send_ready = 1'b0;
    b1.i_enc_done   = 1'b0;
    b1.i_tx_ready   = 1'b1;
  endtask

  task automatic wait_start(input bit hold, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b1.o_send_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("start_seen", ok, 1'b1);
    if (ok) begin
      chk("ack_at_start", ack, 1'b1);
      chk("busy_at_start", busy, 1'b1);
      chk("byte_count_clr", byte_cnt, 0);
      chk("err_clr", err, 1'b0);
      bc_m = '0;
    end
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  // Plays the send controller (header bytes, ready, data bytes, encoder done,
  // final byte with end flag) and a random downstream sink for one frame.
  task automatic run_frame(input int n_hdr, input int n_dat, input int v_pct,
                           input int r_pct, input int stall_len,
                           input bit stray_done, input bit hold);
    int         kind[$];
    logic [7:0] dat[$];
    bit         efl[$];
    bit         ok, cap, en_exp;
    int         idx, stall, guard, k;
    if (stray_done) begin kind.push_back(3); dat.push_back(8'h00); efl.push_back(1'b0); end
    for (int i = 0; i < n_hdr; i++) begin kind.push_back(0); dat.push_back(8'($urandom)); efl.push_back(1'b0); end
    kind.push_back(1); dat.push_back(8'h00); efl.push_back(1'b0);
    for (int i = 0; i < n_dat - 1; i++) begin kind.push_back(0); dat.push_back(8'($urandom)); efl.push_back(1'b0); end
    kind.push_back(2); dat.push_back(8'h00); efl.push_back(1'b0);
    kind.push_back(0); dat.push_back(8'($urandom)); efl.push_back(1'b1);
    wait_start(hold, ok);
    if (!ok) return;
    idx = 0; stall = 0; guard = 0; en_exp = 1'b0;
    while (idx < kind.size() && guard < 2000) begin
      guard++;
      k = kind[idx];
      b1.i_send_valid = (k == 0) && ($urandom_range(99) < v_pct);
      b1.i_send_data  = b1.i_send_valid ? dat[idx] : 8'($urandom);
      b1.i_send_end   = b1.i_send_valid && efl[idx];
      b1.i_send_ready = (k == 1);
      b1.i_enc_done   = (k == 2) || (k == 3);
      b1.i_tx_ready   = (stall > 0) ? 1'b0 : ($urandom_range(99) < r_pct);
      @(negedge clk);
      chk("enc_enable", b1.o_enc_enable, en_exp);
      chk("ack_while_busy", ack, 1'b0);
      chk("busy_in_frame", busy, 1'b1);
      tick(cap);
      if (stall > 0) stall--;
      if (k == 0) begin
        if (cap) idx++;
      end else begin
        idx++;
        if (k == 1) begin en_exp = 1'b1; stall = stall_len; end
        if (k == 2) de_exp = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("items_done", idx, kind.size());
    idle_inputs();
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      tick(cap);
      @(posedge clk); #1;
    end
    chk("frame_end_idle", busy, 1'b0);
    fc_m++;
    chk("frame_count", frame_cnt, fc_m);
    chk("byte_count_end", byte_cnt, bc_m);
    chk("enc_off_idle", b1.o_enc_enable, 1'b0);
    chk("tx_empty_idle", b1.o_tx_valid, 1'b0);
    chk("ack_in_idle", ack, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    idle_inputs();
    b2.i_send_valid = 1'b0; b2.i_send_data = 8'h00; b2.i_send_end = 1'b0;
    b2.i_send_ready = 1'b0; b2.i_enc_done = 1'b0;   b2.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_start", b1.o_send_start, 1'b0);
    chk("rst_wait", b1.o_send_wait, 1'b0);
    chk("rst_data_end", b1.o_send_data_end, 1'b0);
    chk("rst_enc", b1.o_enc_enable, 1'b0);
    chk("rst_tx_valid", b1.o_tx_valid, 1'b0);
    chk("rst_tx_data", b1.o_tx_data, 8'h00);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset in the middle of DATA with both FIFO entries occupied.
    req = 1'b1;
    wait_start(1'b0, ok);
    b1.i_send_ready = 1'b1; b1.i_tx_ready = 1'b0;
    @(posedge clk); #1;
    b1.i_send_ready = 1'b0; b1.i_send_valid = 1'b1; b1.i_send_data = 8'hA5;
    @(posedge clk); #1;
    b1.i_send_data = 8'h3C;
    @(posedge clk); #1;
    b1.i_send_valid = 1'b0;
    @(negedge clk);
    chk("mid_tx_valid", b1.o_tx_valid, 1'b1);
    chk("mid_wait", b1.o_send_wait, 1'b1);
    chk("mid_tx_data", b1.o_tx_data, 8'hA5);
    #1 rst = 1'b1;
    #1;
    chk("arst_tx_valid", b1.o_tx_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_wait", b1.o_send_wait, 1'b0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_byte_cnt", byte_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    mq.delete(); bc_m = '0; fc_m = '0; de_exp = 1'b0;
    @(posedge clk); #1;

    // Basic frame: 4 header bytes, 3 data bytes, sink always ready.
    req = 1'b1;
    run_frame(4, 3, 100, 100, 0, 1'b1, 1'b0);
    chk("basic_bytes", byte_cnt, 7);
    chk("basic_frames", frame_cnt, 1);

    // Downstream stalled for 10 cycles after header; encoder done lands while stalled.
    req = 1'b1;
    run_frame(4, 3, 100, 100, 10, 1'b0, 1'b0);
    chk("stall_bytes", byte_cnt, 7);
    chk("stall_frames", frame_cnt, 2);

    // Random back-to-back frames with the request held high throughout.
    req = 1'b1;
    for (int f = 0; f < 15; f++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(40, 100),
                $urandom_range(30, 100), $urandom_range(0, 4), 1'b0, f != 14);
    req = 1'b0;
    chk("rand_frames", frame_cnt, 17);

    // Header timeout on the short-timeout instance.
    req2 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b2.o_send_start === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("to_start_seen", ok, 1'b1);
    chk("to_ack", ack2, 1'b1);
    @(posedge clk); #1;
    req2 = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("to_busy_hdr", busy2, 1'b1);
      chk("to_err_early", err2, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_err", err2, 1'b1);
    chk("to_idle", busy2, 1'b0);
    chk("to_enc_off", b2.o_enc_enable, 1'b0);
    chk("to_frames", frame_cnt2, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("to_err_sticky", err2, 1'b1);
    @(posedge clk); #1;
    req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(negedge clk);
    chk("to_err_clr", err2, 1'b0);
    chk("to_restart", b2.o_send_start, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/send_sched.md
SEND_SCHED -- requirements
Module: send_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 4095, max idle cycles in HEADER/FLUSH before abort.
REQ-002 Parameter CNT_W, default 32, width of byte counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_frame_req  input  1  host request to encode and send one frame (level).
REQ-006 o_frame_ack  output  1  one-cycle pulse when a request is accepted.
REQ-007 o_busy  output  1  high in any state other than IDLE.
REQ-008 o_send_start  output  1  start pulse to the send controller.
REQ-009 o_send_wait  output  1  stall to the send controller (freezes it).
REQ-010 i_send_ready  input  1  send controller header-done flag.
REQ-011 i_send_data/i_send_valid/i_send_end  input  8/1/1  send controller byte stream and end-of-image flag.
REQ-012 o_send_data_end  output  1  end-of-entropy-data indication to the send controller.
REQ-013 o_enc_enable  output  1  enables the entropy encoder.
REQ-014 i_enc_done  input  1  one-cycle pulse, encoder produced its last byte.
REQ-015 o_tx_data/o_tx_valid  output  8/1; i_tx_ready  input  1  downstream valid/ready byte port.
REQ-016 o_byte_count  output  CNT_W  bytes transferred downstream in the current frame; o_frame_count  output  16  frames completed; o_err_timeout  output  1  sticky abort flag.

Function
REQ-017 FSM states: IDLE, START, HEADER, DATA, FLUSH, DONE.
REQ-018 IDLE: i_frame_req=1 -> START; o_frame_ack pulses that cycle; o_byte_count and o_err_timeout clear.
REQ-019 START: o_send_start=1 for exactly one cycle -> HEADER.
REQ-020 HEADER: i_send_ready=1 -> DATA; o_enc_enable=1 from the DATA entry cycle until FLUSH exit.
REQ-021 DATA: i_enc_done=1 -> FLUSH; o_send_data_end asserts, held until a cycle with o_send_wait=0, then drops (exactly one unstalled cycle).
REQ-022 FLUSH: after a captured byte with i_send_end=1 and FIFO empty -> DONE.
REQ-023 DONE: o_frame_count increments by 1 (wraps at 2^16) -> IDLE in one cycle.
REQ-024 Byte capture: i_send_valid=1 and o_send_wait=0 writes i_send_data into a 2-entry FIFO; a byte is never captured while o_send_wait=1.
REQ-025 o_send_wait = (FIFO count == 2), combinational; a same-cycle pop does not release it.
REQ-026 o_tx_valid = FIFO not empty; o_tx_data = FIFO head; pop on o_tx_valid & i_tx_ready; o_byte_count increments per pop, wraps modulo 2^CNT_W.
REQ-027 Simultaneous push and pop at count 1 keeps count 1; at count 0 the push occurs with no pop (no bypass).
REQ-028 Timeout counter: counts cycles in HEADER or FLUSH with no capture, clears on capture or state change; reaching TIMEOUT_CYC sets o_err_timeout, flushes FIFO, -> IDLE.
REQ-029 i_frame_req while busy is ignored; no o_frame_ack.
REQ-030 i_enc_done outside DATA is ignored.

Reset
REQ-031 rst=1 asynchronously forces IDLE; FIFO empty; all outputs 0; counters 0; o_err_timeout 0.
REQ-032 Reset mid-frame discards buffered bytes; o_frame_count does not increment.

Structure
REQ-033 Package jpeg_pkg holds the state enum type and localparam SCHED_FIFO_DEPTH=2.
REQ-034 FIFO implemented as sub-module byte_fifo2 (push, pop, data, count, flush).

Verification
REQ-035 Request, send controller emits 4 header bytes, ready, 3 data bytes, end, i_tx_ready=1 -> o_tx_data sequence intact, o_byte_count=7, o_frame_count=1.
REQ-036 i_tx_ready=0 for 10 cycles during DATA -> o_send_wait=1 once 2 bytes held; no byte lost or duplicated after release.
REQ-037 i_enc_done while o_send_wait=1 -> o_send_data_end held until the first unstalled cycle, asserted exactly one unstalled cycle.
REQ-038 TIMEOUT_CYC=16, i_send_ready never asserted -> o_err_timeout=1 on cycle 16 of HEADER, state IDLE, o_busy=0.
REQ-039 rst pulse mid-DATA with 2 bytes buffered -> o_tx_valid=0 immediately, o_frame_count unchanged.
REQ-040 i_frame_req held high across DONE -> second frame accepted with a single ack per frame.
